// File: rtl/resp_demux_4_pkg.sv
// Shared types and constants for the read-response demultiplexer.
// Destinations are 2-bit indices; routed responses use a one-hot strobe per destination.
package resp_demux_4_pkg;

  localparam int NUM_DEST  = 4;
  localparam int DEST_W    = 2;
  localparam int TAG_DEPTH = 4;
  localparam int PTR_W     = 2;
  localparam int CNT_W     = 3;

  typedef logic [DEST_W-1:0]   dest_t;
  typedef logic [NUM_DEST-1:0] dest_onehot_t;
  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  function automatic dest_onehot_t dest_decode(input dest_t d);
    dest_onehot_t oh;
    oh    = '0;
    oh[d] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/resp_demux_4_tag_fifo.sv
// Four-entry FIFO of destination tags; the head tag names the owner of the next response.
// Pointers wrap modulo 4 and a separate occupancy count tells full from empty.
module tag_fifo
  import resp_demux_4_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push_i,
  input  dest_t push_tag_i,
  input  logic  pop_i,
  output dest_t head_tag_o,
  output logic  full_o,
  output logic  empty_o,
  output cnt_t  count_o
);

  dest_t mem_q [TAG_DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  push_ok, pop_ok;

  assign full_o     = (count_q == cnt_t'(TAG_DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_tag_o = mem_q[rd_ptr_q];

  // A push into a full queue is dropped even when a pop frees a slot this cycle,
  // and a pop from an empty queue never sees a same-cycle push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem_q[wr_ptr_q] <= push_tag_i;
  end

endmodule

// File: rtl/resp_demux_4.sv
// Routes in-order read responses on a shared bus back to one of four requesters.
// Outputs are registered: a response in cycle N appears on out_valid/out_data in cycle N+1.
module resp_demux_4
  import resp_demux_4_pkg::*;
#(
  parameter int BUS_WIDTH = 31
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_issue,
  input  logic [DEST_W-1:0]   req_dest,
  output logic                req_stall,
  input  logic                resp_valid,
  input  logic [BUS_WIDTH:0]  resp_data,
  output logic [NUM_DEST-1:0] out_valid,
  output logic [BUS_WIDTH:0]  out_data,
  output logic [CNT_W-1:0]    pending,
  output logic                resp_orphan
);

  dest_t          head_tag;
  logic           fifo_full, fifo_empty;
  cnt_t           fifo_count;
  logic           pop;

  dest_onehot_t   out_valid_q, out_valid_d;
  logic [BUS_WIDTH:0] out_data_q, out_data_d;
  logic           orphan_q, orphan_d;

  assign pop = resp_valid && !fifo_empty;

  tag_fifo u_tag_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (req_issue),
    .push_tag_i (req_dest),
    .pop_i      (resp_valid),
    .head_tag_o (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Orphan words are dropped silently apart from the sticky flag.
  always_comb begin
    out_valid_d = '0;
    out_data_d  = out_data_q;
    orphan_d    = orphan_q || (resp_valid && fifo_empty);
    if (pop) begin
      out_valid_d = dest_decode(head_tag);
      out_data_d  = resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      orphan_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      orphan_q    <= orphan_d;
    end
  end

  assign req_stall   = fifo_full;
  assign pending     = fifo_count;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign resp_orphan = orphan_q;

endmodule

// File: tb/tb_resp_demux_4.sv
// Randomized scoreboard bench for resp_demux_4 against a queue-based reference model.
module tb_resp_demux_4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_issue;
  logic [1:0]  req_dest;
  logic        req_stall;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [2:0]  pending;
  logic        resp_orphan;

  resp_demux_4 #(.BUS_WIDTH(31)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_issue   (req_issue),
    .req_dest    (req_dest),
    .req_stall   (req_stall),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .pending     (pending),
    .resp_orphan (resp_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  ov;
    logic [31:0] d;
  } exp_t;

  int          vecs = 0;
  int          errs = 0;
  int          edge_n = 0;
  int          mq[$];
  exp_t        sbq[$];
  logic        m_orphan = 1'b0;
  logic [31:0] m_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // One clock of stimulus; the model is advanced from the rules of the block.
  task automatic step(input logic iss, input logic [1:0] d, input logic rv, input logic [31:0] data);
    int   sz;
    int   t;
    exp_t e;
    req_issue  = iss;
    req_dest   = d;
    resp_valid = rv;
    resp_data  = data;
    @(posedge clk);
    edge_n++;
    if (!reset_n) begin
      mq.delete();
      sbq.delete();
      m_orphan = 1'b0;
      m_data   = '0;
    end else begin
      sz = mq.size();
      if (rv) begin
        if (sz > 0) begin
          t     = mq.pop_front();
          e.cyc = edge_n;
          e.ov  = 4'(1 << t);
          e.d   = data;
          sbq.push_back(e);
          m_data = data;
        end else begin
          m_orphan = 1'b1;
        end
      end
      if (iss && sz < 4) mq.push_back(int'(d));
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, $urandom);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step(1'($urandom), 2'($urandom), 1'($urandom), $urandom);
    reset_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && mq.size() > 0; k++) step(1'b0, 2'd0, 1'b1, $urandom);
    idle();
  endtask

  // Monitor: compares every registered output against the model each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (edge_n > 0) begin
      chk("pending", 64'(pending), 64'(mq.size()));
      chk("req_stall", 64'(req_stall), 64'(mq.size() == 4));
      chk("resp_orphan", 64'(resp_orphan), 64'(m_orphan));
      chk("out_data_hold", 64'(out_data), 64'(m_data));
      chk("onehot", 64'($countones(out_valid) <= 1), 64'(1));
      if (out_valid != 4'b0000 || (sbq.size() > 0 && sbq[0].cyc <= edge_n)) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("out_cycle", 64'(edge_n), 64'(e.cyc));
          chk("out_valid", 64'(out_valid), 64'(e.ov));
          chk("out_data", 64'(out_data), 64'(e.d));
        end
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    req_issue  = 1'b0;
    req_dest   = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    step(1'b1, 2'd3, 1'b1, 32'h1234_5678);
    step(1'b1, 2'd1, 1'b0, 32'h0);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_orphan", 64'(resp_orphan), 64'(0));
    reset_n = 1'b1;
    idle();

    // Single request routing.
    step(1'b1, 2'd2, 1'b0, 32'h0);
    step(1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF);
    chk("single_ov", 64'(out_valid), 64'h4);
    chk("single_od", 64'(out_data), 64'hDEAD_BEEF);
    idle();
    chk("single_ov_clr", 64'(out_valid), 64'h0);

    // Ordering: dests 3,0,1,2 then four back-to-back responses.
    step(1'b1, 2'd3, 1'b0, 32'h0);
    step(1'b1, 2'd0, 1'b0, 32'h0);
    step(1'b1, 2'd1, 1'b0, 32'h0);
    step(1'b1, 2'd2, 1'b0, 32'h0);
    step(1'b0, 2'd0, 1'b1, 32'hAAAA_0001);
    chk("ord_a", 64'(out_valid), 64'h8);
    step(1'b0, 2'd0, 1'b1, 32'hBBBB_0002);
    chk("ord_b", 64'(out_valid), 64'h1);
    step(1'b0, 2'd0, 1'b1, 32'hCCCC_0003);
    chk("ord_c", 64'(out_valid), 64'h2);
    step(1'b0, 2'd0, 1'b1, 32'hDDDD_0004);
    chk("ord_d", 64'(out_valid), 64'h4);
    chk("ord_pend0", 64'(pending), 64'h0);
    idle();

    // Full and stall: fifth issue with same-cycle pop is dropped.
    step(1'b1, 2'd2, 1'b0, 32'h0);
    step(1'b1, 2'd3, 1'b0, 32'h0);
    step(1'b1, 2'd0, 1'b0, 32'h0);
    step(1'b1, 2'd3, 1'b0, 32'h0);
    chk("full_stall", 64'(req_stall), 64'h1);
    step(1'b1, 2'd1, 1'b1, 32'h5555_AAAA);
    chk("full_pend3", 64'(pending), 64'h3);
    chk("full_first_tag", 64'(out_valid), 64'h4);
    drain();

    // Wrap-around: interleaved push/pop with dest pattern 0..3.
    step(1'b1, 2'd0, 1'b0, 32'h0);
    for (int i = 1; i <= 10; i++) step(1'b1, 2'(i % 4), 1'b1, $urandom);
    drain();

    // Orphan with same-cycle push.
    step(1'b1, 2'd0, 1'b1, 32'h0BAD_0BAD);
    chk("orph_ov", 64'(out_valid), 64'h0);
    chk("orph_flag", 64'(resp_orphan), 64'h1);
    chk("orph_pend", 64'(pending), 64'h1);
    step(1'b0, 2'd0, 1'b1, 32'h600D_F00D);
    chk("orph_route0", 64'(out_valid), 64'h1);
    idle();

    // Mid-operation reset with three outstanding tags.
    step(1'b1, 2'd1, 1'b0, 32'h0);
    step(1'b1, 2'd2, 1'b0, 32'h0);
    step(1'b1, 2'd3, 1'b0, 32'h0);
    pulse_reset();
    chk("mrst_pend", 64'(pending), 64'h0);
    chk("mrst_orph_clr", 64'(resp_orphan), 64'h0);
    step(1'b0, 2'd0, 1'b1, 32'h7777_7777);
    chk("mrst_pend2", 64'(pending), 64'h0);
    chk("mrst_ov", 64'(out_valid), 64'h0);
    chk("mrst_orph", 64'(resp_orphan), 64'h1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step(1'($urandom_range(0, 99) < 55), 2'($urandom), 1'($urandom_range(0, 99) < 50), $urandom);
    end
    drain();
    idle();
    chk("sb_empty", 64'(sbq.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/resp_demux_4.md
RESP_DEMUX_4 -- requirements
Module: resp_demux_4

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 31, where every data bus is [BUS_WIDTH:0] (BUS_WIDTH+1 bits).
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 Port req_issue, input, 1: a read request is issued on the shared bus this cycle.
REQ-005 Port req_dest, input, 2: the destination index 0-3 of the issued request.
REQ-006 Port req_stall, output, 1: the tag queue is full and the issuer must hold off.
REQ-007 Port resp_valid, input, 1: a read response word is present this cycle.
REQ-008 Port resp_data, input, BUS_WIDTH+1: the read response word.
REQ-009 Port out_valid, output, 4: one-hot, with bit N meaning out_data is for destination N.
REQ-010 Port out_data, output, BUS_WIDTH+1: the routed response word, shared by all destinations.
REQ-011 Port pending, output, 3: the number of outstanding tags, 0-4.
REQ-012 Port resp_orphan, output, 1: sticky error flag, set when a response arrives with no outstanding tag.

Function
REQ-013 The block SHALL hold a 4-entry FIFO of 2-bit destination tags, returning responses strictly in issue order.
REQ-014 Push: on req_issue=1 with pending<4, req_dest SHALL be written at the tail and pending SHALL increment.
REQ-015 req_stall SHALL be combinational and equal (pending==4).
REQ-016 req_issue while pending==4 SHALL be ignored, with the queue unchanged, even if a pop occurs that same cycle.
REQ-017 Pop: on resp_valid=1 with pending>0, the head tag T SHALL be removed.
REQ-018 On that pop, out_data<=resp_data and out_valid<=(1<<T) SHALL be registered, so the output appears in cycle N+1 for a response in cycle N.
REQ-019 out_valid SHALL be 4'b0000 in every cycle that follows a cycle with no pop; out_data SHALL hold its last value.
REQ-020 out_valid SHALL never have more than one bit set.
REQ-021 A simultaneous push and pop with 0<pending<4 SHALL leave pending unchanged and preserve FIFO order.
REQ-022 resp_valid with pending==0 SHALL discard the word, keep out_valid at 0 and set resp_orphan.
  - This holds even if req_issue=1 in the same cycle; there is no push-to-pop bypass.
  - The push in that cycle still occurs.
REQ-023 resp_orphan SHALL remain set until reset.
REQ-024 Read and write pointers SHALL be 2 bits and wrap modulo 4; pending SHALL be tracked separately to distinguish full from empty.

Reset
REQ-025 While reset_n=0 at a rising edge, the block SHALL clear out_valid=0, out_data=0, pending=0, resp_orphan=0 and both pointers.
REQ-026 Reset asserted mid-operation SHALL drop all outstanding tags.
  - A response in the cycle after reset deassertion SHALL be treated as an orphan.
REQ-027 Inputs sampled in a reset cycle SHALL have no effect.

Structure
REQ-028 Shared package contents SHALL be:
  - constants NUM_DEST=4, DEST_W=2, TAG_DEPTH=4;
  - typedef dest_t (logic [DEST_W-1:0]);
  - typedef dest_onehot_t (logic [NUM_DEST-1:0]).
REQ-029 The tag queue SHALL be a separate sub-module, tag_fifo, with push/pop/full/empty/count ports.
  - The top level contains only the output registers, the one-hot decode and the orphan flag.

Verification
REQ-030 The bench SHALL cover single-request routing:
  - Stimulus: issue dest=2, then one cycle later resp 0xDEADBEEF.
  - Required response: the next cycle out_valid=4'b0100 and out_data=0xDEADBEEF; the following cycle out_valid=0.
REQ-031 The bench SHALL cover ordering:
  - Stimulus: issue dests 3,0,1,2, then four back-to-back responses A,B,C,D.
  - Required response: out_valid sequence 1000,0001,0010,0100 carrying A,B,C,D; pending returns to 0.
REQ-032 The bench SHALL cover full and stall:
  - Stimulus: 4 issues, then a 5th issue (dest=1) with resp_valid=1 in the same cycle.
  - Required response: req_stall=1 before that cycle; the 5th issue is dropped; pending goes 4->3; the popped tag is the first-issued one.
REQ-033 The bench SHALL cover wrap-around:
  - Stimulus: 10 interleaved push/pop pairs with a running dest pattern 0..3.
  - Required response: every output matches a reference FIFO model; pending never exceeds 4.
REQ-034 The bench SHALL cover orphan handling:
  - Stimulus: resp_valid=1 with pending=0 and req_issue=1 (dest=0) in the same cycle.
  - Required response: out_valid stays 0 and resp_orphan=1; pending=1; the next response routes to dest 0.
REQ-035 The bench SHALL cover mid-operation reset:
  - Stimulus: 3 outstanding tags, then reset_n=0 for 1 cycle, then resp_valid=1.
  - Required response: pending=0, out_valid=0 and resp_orphan=1.
